// File: rtl/mem_copy_dma.sv
// Word-serial block copy initiator for the single-port block RAM; three cycles per word (read, latency, write).
// Optional MEM_COPY_DMA_CHECKSUM_EN adds a running sum of copied words; otherwise checksum reads 0.
module mem_copy_dma #(
   parameter int unsigned SIZE  = 14,
   parameter int unsigned LEN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SIZE-1:0]  src_addr,
   input  logic [SIZE-1:0]  dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [31:0]      checksum,
   output logic             wrEn,
   output logic [SIZE-1:0]  addr_toRam,
   output logic [31:0]      data_toRam,
   input  logic [31:0]      data_fromRam
);

   typedef enum logic [2:0] {StIdle, StRd, StLat, StWr, StDone} state_e;

   state_e           state_q;
   logic [SIZE-1:0]  src_q;      // next source address to read
   logic [SIZE-1:0]  dst_q;      // next destination address to write
   logic [LEN_W-1:0] rem_q;      // words still to be written, including the current one
   logic             busy_q;
   logic             done_q;
   logic             wr_en_q;
   logic [SIZE-1:0]  addr_q;
   logic [31:0]      wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  dst_q <= dst_addr;
                  rem_q <= len;
                  if (len == '0) begin
                     // Empty request: report completion without touching the bus.
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     busy_q  <= 1'b1;
                     addr_q  <= src_addr;
                     src_q   <= src_addr + SIZE'(1);
                     state_q <= StRd;
                  end
               end
            end
            StRd: begin
               state_q <= StLat;
            end
            StLat: begin
               // RAM has returned the word addressed during the read cycle.
               wdata_q <= data_fromRam;
               addr_q  <= dst_q;
               dst_q   <= dst_q + SIZE'(1);
               wr_en_q <= 1'b1;
               state_q <= StWr;
            end
            StWr: begin
               wr_en_q <= 1'b0;
               rem_q   <= rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  addr_q  <= src_q;
                  src_q   <= src_q + SIZE'(1);
                  state_q <= StRd;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               wr_en_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef MEM_COPY_DMA_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else if (state_q == StIdle && start) begin
         sum_q <= '0;
      end else if (state_q == StLat) begin
         sum_q <= sum_q + data_fromRam;
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = 32'h0;
`endif

   assign busy       = busy_q;
   assign done       = done_q;
   assign wrEn       = wr_en_q;
   assign addr_toRam = addr_q;
   assign data_toRam = wdata_q;

endmodule
